dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory access controller for the cqu_mips five-stage pipeline. Sequences a single-port, 1-cycle-read-latency data RAM and shares it between two requesters: the MEM-stage load/store port (pipeline) and an auxiliary port (program loader / debug). Sits between the memory access stage and the data RAM macro. Generates the pipeline stall while a pipeline access is outstanding.

## Interface
- ADDR_W, 10, word-address width of the RAM (1024 words).
- STARVE_MAX, 4, consecutive pipeline grants tolerated while aux waits (fairness build only).

- clk  in  1  clock, all state on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- p_req  in  1  pipeline request; held stable until p_done.
- p_we  in  1  pipeline write (1) / read (0).
- p_addr  in  32  pipeline byte address; bits [1:0] ignored.
- p_wdata  in  32  pipeline store data.
- p_rdata  out  32  pipeline load data, valid only with p_done on a read.
- p_done  out  1  one-cycle completion pulse, pipeline.
- stall  out  1  pipeline stall = p_req & ~p_done.
- a_req, a_we, a_addr, a_wdata, a_rdata, a_done: same as p_* for the aux port.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable, qualified by ram_en.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en & ~ram_we.

## Operation
- States: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: if no request, stay. Otherwise arbitrate, register grant (gnt = P or A), latch we/addr/wdata of winner, go ACCESS.
- Arbitration: pipeline wins when both request, except fairness override (Configuration).
- ACCESS: ram_en = 1 iff latched word address addr[31:2] < 2**ADDR_W; ram_we = latched we; ram_addr = addr[ADDR_W+1:2]; ram_wdata = latched wdata. Go RESP.
- RESP: pulse done of granted port; read data to that port = ram_rdata if in range, else 0. Go IDLE.
- Out-of-range write: dropped (ram_en stays 0), done still pulses. Out-of-range read returns 0.
- Non-granted port rdata and done are 0 every cycle; p_rdata/a_rdata are 0 outside RESP.
- A requester keeping req high after its done is treated as a new request in the following IDLE cycle.
- Changing req/addr/data before done: undefined for the requester; the controller uses latched values and the transaction completes unchanged.

## Timing
- Latency: req high at IDLE edge k -> ACCESS in cycle k+1 -> done in cycle k+2. Back-to-back throughput: one access per 3 cycles.
- Reset values: ram_en, ram_we, p_done, a_done = 0; ram_addr, ram_wdata, p_rdata, a_rdata = 0; stall = p_req (combinational); starve counter = 0.
- Reset mid-operation: FSM to IDLE immediately, transaction aborted, no done pulse, no RAM write if asserted before the ACCESS edge.
- Simultaneous p_req and a_req in IDLE: one grant only; the loser waits and is sampled again in the next IDLE.
- stall is combinational from p_req and state; no registered delay.

## Configuration
- DMEM_CTRL_FAIRNESS_EN defined: a 3-bit starve counter increments on each pipeline grant made while a_req = 1. It clears on any aux grant, or on an IDLE arbitration with a_req = 0. When counter == STARVE_MAX and a_req = 1, aux wins even if p_req = 1.
- Not defined: strict pipeline priority; counter absent; aux can starve indefinitely.

## Test plan
- Reset then pipeline write 0xDEADBEEF to byte 0x10, then read 0x10 -> ram_en/ram_we in cycle k+1 with ram_addr 4; read p_done at k+2 with p_rdata = 0xDEADBEEF; stall high exactly 2 cycles per access.
- p_req and a_req asserted the same cycle -> pipeline done first at k+2, aux granted in the next IDLE, a_done at k+5.
- Fairness build: p_req held continuously, a_req high -> aux granted after 4 pipeline grants. Without the macro -> a_done never pulses within 50 cycles.
- Access to byte 0x1000 (word 1024) -> ram_en stays 0; read returns p_rdata = 0; p_done still at k+2.
- rstn low during ACCESS of a write -> no done pulse; all outputs 0; FSM returns to IDLE; a subsequent read of that address returns the prior RAM contents.

Source files
------------

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Data-memory access controller for the cqu_mips pipeline. Shares a single-port
// data RAM (1-cycle read latency) between the MEM-stage load/store port (p_*)
// and an auxiliary loader/debug port (a_*). Each access walks IDLE -> ACCESS ->
// RESP, so the requester sees its done pulse two cycles after being sampled.
//
// Optional build macro: DMEM_CTRL_FAIRNESS_EN
//   defined   : a starve counter lets aux win after STARVE_MAX consecutive
//               pipeline grants made while aux was waiting.
//   undefined : strict pipeline priority, aux may starve.
//
// Ports
//   clk, rstn                    clock, asynchronous active-low reset
//   p_req/p_we/p_addr/p_wdata    pipeline request (byte address, [1:0] ignored)
//   p_rdata/p_done               pipeline load data / one-cycle completion pulse
//   stall                        p_req & ~p_done (combinational)
//   a_req/a_we/a_addr/a_wdata    aux request
//   a_rdata/a_done               aux load data / completion pulse
//   ram_en/ram_we/ram_addr/ram_wdata  RAM strobe, write enable, word addr, data
//   ram_rdata                    RAM read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [31:0]       p_addr,
  input  logic [31:0]       p_wdata,
  output logic [31:0]       p_rdata,
  output logic              p_done,
  output logic              stall,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [31:0]       a_addr,
  input  logic [31:0]       a_wdata,
  output logic [31:0]       a_rdata,
  output logic              a_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic                grant_s;      // an arbitration is made this cycle
  logic                grant_a_s;    // ... and aux is the winner
  logic                sel_we_s;
  logic [29:0]         sel_word_s;
  logic [31:0]         sel_wdata_s;
  logic                sel_in_range_s;

  logic                gnt_a_r;
  logic                we_r;
  logic                in_range_r;
  logic                ram_en_r, ram_we_r;
  logic [ADDR_W-1:0]   ram_addr_r;
  logic [31:0]         ram_wdata_r;
  logic                p_done_r, a_done_r;
  logic [31:0]         p_rdata_s, a_rdata_s;

  // Byte-offset bits carry no information for word accesses.
  logic unused_s;
  assign unused_s = ^{p_addr[1:0], a_addr[1:0], 3'(STARVE_MAX)};

`ifdef DMEM_CTRL_FAIRNESS_EN
  logic [2:0] starve_cnt_r;
  logic       starve_max_s;
  assign starve_max_s = (starve_cnt_r == 3'(STARVE_MAX));
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic and arbitration.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    grant_a_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (p_req || a_req) begin
          grant_s     = 1'b1;
          state_nxt_s = ACCESS;
`ifdef DMEM_CTRL_FAIRNESS_EN
          grant_a_s   = a_req & (~p_req | starve_max_s);
`else
          grant_a_s   = ~p_req;
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS:  state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request of the arbitration winner; the range check keeps the RAM from
  // aliasing addresses beyond its depth.
  always_comb begin
    if (grant_a_s) begin
      sel_we_s    = a_we;
      sel_word_s  = a_addr[31:2];
      sel_wdata_s = a_wdata;
    end else begin
      sel_we_s    = p_we;
      sel_word_s  = p_addr[31:2];
      sel_wdata_s = p_wdata;
    end
    sel_in_range_s = (sel_word_s[29:ADDR_W] == {(30-ADDR_W){1'b0}});
  end

  // Latched transaction attributes needed in RESP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt_a_r    <= 1'b0;
      we_r       <= 1'b0;
      in_range_r <= 1'b0;
    end else if (grant_s) begin
      gnt_a_r    <= grant_a_s;
      we_r       <= sel_we_s;
      in_range_r <= sel_in_range_s;
    end else begin
      gnt_a_r    <= gnt_a_r;
      we_r       <= we_r;
      in_range_r <= in_range_r;
    end
  end

  // RAM strobes are loaded on the grant edge so they are high exactly during
  // ACCESS; an asynchronous reset in ACCESS clears them before the RAM edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ram_en_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_wdata_r <= 32'h0000_0000;
    end else if (grant_s) begin
      ram_en_r    <= sel_in_range_s;
      ram_we_r    <= sel_in_range_s & sel_we_s;
      ram_addr_r  <= sel_word_s[ADDR_W-1:0];
      ram_wdata_r <= sel_wdata_s;
    end else begin
      ram_en_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_wdata_r <= 32'h0000_0000;
    end
  end

  // Done pulses: high for the single RESP cycle of the granted port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_done_r <= 1'b0;
      a_done_r <= 1'b0;
    end else begin
      p_done_r <= (state_r == ACCESS) & ~gnt_a_r;
      a_done_r <= (state_r == ACCESS) &  gnt_a_r;
    end
  end

`ifdef DMEM_CTRL_FAIRNESS_EN
  // Starve counter: counts pipeline grants that made a waiting aux lose.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt_r <= 3'd0;
    end else if (grant_s && grant_a_s) begin
      starve_cnt_r <= 3'd0;
    end else if (grant_s && a_req) begin
      starve_cnt_r <= starve_cnt_r + 3'd1;
    end else if ((state_r == IDLE) && !a_req) begin
      starve_cnt_r <= 3'd0;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`endif

  // Read data is steered straight from the RAM in RESP (it only becomes valid
  // then); out-of-range reads and writes return zero.
  always_comb begin
    p_rdata_s = 32'h0000_0000;
    a_rdata_s = 32'h0000_0000;
    if ((state_r == RESP) && !we_r && in_range_r) begin
      if (gnt_a_r) a_rdata_s = ram_rdata;
      else         p_rdata_s = ram_rdata;
    end else begin
      p_rdata_s = 32'h0000_0000;
      a_rdata_s = 32'h0000_0000;
    end
  end

  assign p_rdata   = p_rdata_s;
  assign a_rdata   = a_rdata_s;
  assign p_done    = p_done_r;
  assign a_done    = a_done_r;
  assign stall     = p_req & ~p_done_r;
  assign ram_en    = ram_en_r;
  assign ram_we    = ram_we_r;
  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: stimulus pushes expected completions and RAM
// strobes into queues, a negedge monitor pops and compares.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        p_req, p_we, a_req, a_we;
  logic [31:0] p_addr, p_wdata, a_addr, a_wdata;
  logic [31:0] p_rdata, a_rdata;
  logic        p_done, a_done, stall;
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

`ifdef DMEM_CTRL_FAIRNESS_EN
  localparam int ASLOT = 4;
`else
  localparam int ASLOT = 16;
`endif

  dmem_ctrl #(.ADDR_W(10), .STARVE_MAX(4)) dut (
    .clk(clk), .rstn(rstn),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_done(p_done), .stall(stall),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_done(a_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model, 1-cycle read latency.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct { int cyc; logic rd; logic [31:0] rdata; } exp_t;
  typedef struct { int cyc; logic we; logic [9:0] addr; logic [31:0] wdata; } ram_exp_t;
  exp_t     p_q[$], a_q[$];
  ram_exp_t r_q[$];

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s: event observed/missing, expected otherwise", name);
  endtask

  // Queue expectations for a transaction sampled in IDLE cycle c.
  task automatic expect_txn(input logic is_a, input int c, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input logic in_rng);
    exp_t e;
    ram_exp_t r;
    e.cyc = c + 2; e.rd = ~we; e.rdata = rdata;
    if (is_a) a_q.push_back(e);
    else      p_q.push_back(e);
    if (in_rng) begin
      r.cyc = c + 1; r.we = we; r.addr = addr[11:2]; r.wdata = wdata;
      r_q.push_back(r);
    end
  endtask

  task automatic drive(input logic is_a, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (is_a) begin a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1; end
    else      begin p_we = we; p_addr = addr; p_wdata = wdata; p_req = 1'b1; end
  endtask

  // Bounded wait for a done pulse; counts stall cycles before it.
  task automatic wait_done(input logic is_a, input logic drop, output int nstall);
    logic seen;
    seen = 1'b0;
    nstall = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (is_a ? a_done : p_done) seen = 1'b1;
      else if (stall) nstall++;
    end
    if (!seen) fail_now(is_a ? "a_done_timeout" : "p_done_timeout");
    if (drop) begin
      if (is_a) a_req = 1'b0;
      else      p_req = 1'b0;
    end
  endtask

  task automatic access(input logic is_a, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic in_rng);
    int ns;
    @(posedge clk); #1;
    expect_txn(is_a, cyc, we, addr, wdata, rdata, in_rng);
    drive(is_a, we, addr, wdata);
    wait_done(is_a, 1'b1, ns);
    if (!is_a) chk("stall_cycles", 32'(ns), 32'd2);
  endtask

  // Monitor.
  exp_t     pe, ae;
  ram_exp_t re;
  always @(negedge clk) begin
    if (rstn) begin
      if (p_done && a_done) fail_now("both_done");
      if (p_done) begin
        if (p_q.size() == 0) fail_now("p_done_unexpected");
        else begin
          pe = p_q.pop_front();
          chk("p_done_cycle", 32'(cyc), 32'(pe.cyc));
          if (pe.rd) chk("p_rdata", p_rdata, pe.rdata);
        end
      end else if (p_rdata !== 32'h0) fail_now("p_rdata_nonzero_outside_done");
      if (a_done) begin
        if (a_q.size() == 0) fail_now("a_done_unexpected");
        else begin
          ae = a_q.pop_front();
          chk("a_done_cycle", 32'(cyc), 32'(ae.cyc));
          if (ae.rd) chk("a_rdata", a_rdata, ae.rdata);
        end
      end else if (a_rdata !== 32'h0) fail_now("a_rdata_nonzero_outside_done");
      if (ram_en) begin
        if (r_q.size() == 0) fail_now("ram_en_unexpected");
        else begin
          re = r_q.pop_front();
          chk("ram_en_cycle", 32'(cyc), 32'(re.cyc));
          chk("ram_we", {31'd0, ram_we}, {31'd0, re.we});
          chk("ram_addr", {22'd0, ram_addr}, {22'd0, re.addr});
          if (re.we) chk("ram_wdata", ram_wdata, re.wdata);
        end
      end
    end
  end

  initial begin
    int ns, c;
    rstn = 1'b0;
    p_req = 1'b0; p_we = 1'b0; p_addr = 32'h0; p_wdata = 32'h0;
    a_req = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_p_done", {31'd0, p_done}, 32'd0);
    chk("rst_a_done", {31'd0, a_done}, 32'd0);
    chk("rst_p_rdata", p_rdata, 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    p_req = 1'b1; #1;
    chk("rst_stall_follows_p_req", {31'd0, stall}, 32'd1);
    p_req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Basic write then read back.
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b1);
    access(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);

    // Simultaneous requests: pipeline first, aux three cycles later.
    @(posedge clk); #1;
    c = cyc;
    expect_txn(1'b0, c, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
    expect_txn(1'b1, c + 3, 1'b1, 32'h40, 32'hCAFEF00D, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 32'h40, 32'hCAFEF00D);
    wait_done(1'b0, 1'b1, ns);
    chk("stall_cycles_contended", 32'(ns), 32'd2);
    wait_done(1'b1, 1'b1, ns);
    access(1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b1);

    // Out-of-range: read returns 0, write to word 1028 must not alias word 4.
    access(1'b0, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'h1010, 32'h12345678, 32'h0, 1'b0);
    access(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);

    // Pipeline held continuously with aux waiting.
    @(posedge clk); #1;
    c = cyc;
    for (int s = 0; s <= 16; s++) begin
      if (s == ASLOT) expect_txn(1'b1, c + 3*s, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b1);
      else            expect_txn(1'b0, c + 3*s, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
    end
    drive(1'b0, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    fork
      begin
        int nsp;
        for (int i = 0; i < 16; i++) wait_done(1'b0, (i == 15), nsp);
      end
      begin
        int nsa;
        wait_done(1'b1, 1'b1, nsa);
      end
    join

    // Reset during ACCESS of a write: aborted, no done, RAM unchanged.
    access(1'b0, 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'h20, 32'h22222222);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("abort_ram_en", {31'd0, ram_en}, 32'd0);
    chk("abort_ram_we", {31'd0, ram_we}, 32'd0);
    chk("abort_ram_addr", {22'd0, ram_addr}, 32'd0);
    chk("abort_ram_wdata", ram_wdata, 32'd0);
    chk("abort_p_done", {31'd0, p_done}, 32'd0);
    chk("abort_p_rdata", p_rdata, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd1);
    p_req = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    access(1'b0, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b1);

    repeat (3) @(negedge clk);
    chk("p_queue_drained", 32'(p_q.size()), 32'd0);
    chk("a_queue_drained", 32'(a_q.size()), 32'd0);
    chk("ram_queue_drained", 32'(r_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
